qkv_bram_writer: RTL and testbench

QKV_BRAM_WRITER -- requirements
Module: qkv_bram_writer

---
 rtl/qkv_bram_writer.sv | 90 +++++++++
 tb/tb_qkv_bram_writer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/qkv_bram_writer.sv
// qkv_bram_writer: packs IN_WIDTH beats into DATA_WIDTH words and writes one tile to BRAM Port A.
module qkv_bram_writer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 256,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_write,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  write_done,
    output logic                  busy
);
    localparam int RATIO = DATA_WIDTH / IN_WIDTH;
    localparam int LW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam logic [1:0] IDLE = 2'd0, PACK = 2'd1, DONE = 2'd2;
    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_q, num_q;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [LW-1:0]         lane;
    logic [DATA_WIDTH-1:0] pack_q, packed_word;
    logic                  accept, last_lane;
    assign s_ready   = state == PACK && word_cnt < {1'b0, num_q};
    assign accept    = s_valid && s_ready;
    assign last_lane = lane == LW'(RATIO - 1);
    assign ena       = wea;
    // The beat being accepted is merged in so the word can be written without a bubble
    always_comb begin
        packed_word = pack_q;
        packed_word[lane*IN_WIDTH +: IN_WIDTH] = s_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_q     <= '0;
            num_q      <= '0;
            word_cnt   <= '0;
            lane       <= '0;
            pack_q     <= '0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            write_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wea        <= 1'b0;
            write_done <= 1'b0;
            case (state)
                IDLE: if (start_write) begin
                    base_q     <= base_addr;
                    num_q      <= num_words;
                    word_cnt   <= '0;
                    lane       <= '0;
                    busy       <= 1'b1;
                    state      <= num_words == '0 ? DONE : PACK;
                    write_done <= num_words == '0;
                end
                PACK: begin
                    if (accept) begin
                        pack_q <= packed_word;
                        lane   <= last_lane ? '0 : lane + 1'b1;
                        if (last_lane) begin
                            word_cnt <= word_cnt + 1'b1;
                            wea      <= 1'b1;
                            addra    <= base_q + word_cnt[ADDR_WIDTH-1:0];
                            dina     <= packed_word;
                        end
                    end
                    // The final word's write cycle is the last cycle spent in PACK
                    if (wea && word_cnt == {1'b0, num_q}) begin
                        state      <= DONE;
                        write_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qkv_bram_writer.sv
// tb_qkv_bram_writer: vector table plus random tiles checked against a transaction-level model.
module tb_qkv_bram_writer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_write = 1'b0;
    logic [15:0]  base_addr = '0;
    logic [15:0]  num_words = '0;
    logic         s_valid = 1'b0;
    logic [63:0]  s_data = '0;
    logic         s_ready, ena, wea, write_done, busy;
    logic [15:0]  addra;
    logic [255:0] dina;

    qkv_bram_writer dut (
        .clk(clk), .rst_n(rst_n), .start_write(start_write), .base_addr(base_addr),
        .num_words(num_words), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .write_done(write_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] base;
        logic [15:0] nw;
        int          mode;
        bit          restart;
        logic [15:0] alt_base;
        int          exp_writes;
        logic [15:0] exp_first;
        logic [15:0] exp_last;
    } vec_t;

    int checks = 0, fails = 0;
    logic [15:0]  m_base;
    int           m_total = 0, m_n = 0, cyc = 0, done_at = -10;
    logic [63:0]  m_lane[$];
    bit           m_busy = 0, exp_wea;
    logic [15:0]  exp_addr, hold_addr = '0;
    logic [255:0] exp_data, hold_data = '0;
    int           w_count;
    logic [15:0]  w_first, w_last;
    logic [255:0] w_first_data, w_last_data;
    vec_t         tv[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit sv, input logic [63:0] sd, input bit st,
                        input logic [15:0] ba, input logic [15:0] nw, output bit acc);
        bit rdy, st_acc;
        s_valid = sv; s_data = sd; start_write = st; base_addr = ba; num_words = nw;
        #1;
        rdy = m_busy && m_n < m_total;
        chk("s_ready", s_ready, rdy);
        acc = sv && rdy;
        st_acc = st && !m_busy;
        exp_wea = 0;
        if (acc) begin
            m_lane.push_back(sd);
            m_n++;
            if (m_lane.size() == 4) begin
                exp_wea  = 1;
                exp_addr = m_base + 16'((m_n / 4) - 1);
                exp_data = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
                m_lane.delete();
            end
            if (m_n == m_total) done_at = cyc + 2;
        end
        if (st_acc) begin
            m_base = ba; m_total = int'(nw) * 4; m_n = 0; m_lane.delete();
            if (nw == 0) done_at = cyc + 1;
        end
        @(posedge clk); #1;
        cyc++;
        if (st_acc) m_busy = 1;
        else if (cyc == done_at + 1) m_busy = 0;
        chk("wea", wea, exp_wea);
        chk("ena", ena, exp_wea);
        chk("write_done", write_done, cyc == done_at);
        chk("busy", busy, m_busy);
        if (exp_wea) begin
            hold_addr = exp_addr; hold_data = exp_data;
            if (w_count == 0) begin w_first = exp_addr; w_first_data = exp_data; end
            w_last = exp_addr; w_last_data = exp_data;
            w_count++;
        end
        chk("addra", addra, hold_addr);
        chk("dina", dina, hold_data);
    endtask

    task automatic do_reset();
        #2 rst_n = 0;
        s_valid = 0; start_write = 0;
        #1;
        chk("rst_ena", ena, 0); chk("rst_wea", wea, 0); chk("rst_done", write_done, 0);
        chk("rst_busy", busy, 0); chk("rst_ready", s_ready, 0);
        chk("rst_addra", addra, 0); chk("rst_dina", dina, 0);
        m_busy = 0; m_n = 0; m_total = 0; m_lane.delete(); done_at = -10;
        hold_addr = '0; hold_data = '0;
        @(posedge clk); #3 rst_n = 1;
    endtask

    task automatic run_tile(input vec_t v);
        bit acc, sv;
        int guard = 0;
        logic [63:0] sd;
        w_count = 0;
        step(0, 0, 1, v.base, v.nw, acc);
        while (m_n < m_total && guard < 400) begin
            sv = v.mode == 0 ? 1'b1 : v.mode == 1 ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            sd = v.mode == 2 ? {$urandom, $urandom} : 64'(m_n + 1);
            step(sv, sd, v.restart && m_n == 3, v.alt_base, v.nw + 16'd1, acc);
            guard++;
        end
        if (guard >= 400) begin
            checks++; fails++;
            $display("FAIL tile_timeout: got %0d beats expected %0d", m_n, m_total);
        end
        repeat (4) step(0, 0, 0, 0, 0, acc);
        chk("write_count", w_count, v.exp_writes);
        if (v.exp_writes > 0) begin
            chk("first_addr", w_first, v.exp_first);
            chk("last_addr", w_last, v.exp_last);
        end
    endtask

    initial begin
        bit acc;
        vec_t r;
        tv[0] = '{16'h0010, 16'd2, 0, 0, 16'h0000, 2, 16'h0010, 16'h0011};
        tv[1] = '{16'h0010, 16'd2, 1, 0, 16'h0000, 2, 16'h0010, 16'h0011};
        tv[2] = '{16'h0040, 16'd0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        tv[3] = '{16'hFFFF, 16'd2, 2, 0, 16'h0000, 2, 16'hFFFF, 16'h0000};
        tv[4] = '{16'h0100, 16'd2, 0, 1, 16'h5555, 2, 16'h0100, 16'h0101};
        tv[5] = '{16'h1234, 16'd5, 2, 0, 16'h0000, 5, 16'h1234, 16'h1238};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_tile(tv[i]);
            if (tv[i].mode != 2 && tv[i].exp_writes == 2) begin
                chk("word0_lanes", w_first_data, {64'd4, 64'd3, 64'd2, 64'd1});
                chk("word1_lanes", w_last_data, {64'd8, 64'd7, 64'd6, 64'd5});
            end
        end
        step(0, 0, 1, 16'h0020, 16'd2, acc);
        for (int k = 0; k < 5; k++) step(1, {$urandom, $urandom}, 0, 0, 0, acc);
        do_reset();
        w_count = 0;
        repeat (3) step(0, 0, 0, 0, 0, acc);
        chk("no_write_after_reset", w_count, 0);
        run_tile(tv[0]);
        chk("post_reset_word0", w_first_data, {64'd4, 64'd3, 64'd2, 64'd1});
        for (int t = 0; t < 10; t++) begin
            r.base = 16'($urandom);
            r.nw = 16'($urandom_range(0, 5));
            r.mode = 2; r.restart = 1'($urandom_range(0, 1)); r.alt_base = 16'($urandom);
            r.exp_writes = int'(r.nw);
            r.exp_first = r.base;
            r.exp_last = r.base + r.nw - 16'd1;
            run_tile(r);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
